// File: rtl/lfsr_param.sv
// Parametrised Galois LFSR with seed loading, step enable and on-line period
// measurement against the state the current sequence started from.
module lfsr_param #(
  parameter int unsigned           WIDTH = 6,
  parameter logic [WIDTH-1:0]      TAPS  = WIDTH'(6'b000100),
  parameter logic [WIDTH-1:0]      SEED  = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_o,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] period_o,
  output logic             period_vld_o,
  output logic             seed_err_o
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_param: WIDTH must be in 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_param: SEED must be non-zero");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_vld_q, period_vld_d;
  logic             wrap_q, wrap_d;
  logic             seed_err_q, seed_err_d;

  logic             fb;
  logic [WIDTH-1:0] step_mask;
  logic [WIDTH-1:0] step_n;
  logic [WIDTH-1:0] count_inc;

  // Bit 0 of the mask is forced so the feedback bit always lands in stage 0;
  // TAPS[0] is deliberately ignored.
  assign fb        = q_q[WIDTH-1];
  assign step_mask = {TAPS[WIDTH-1:1], 1'b1};
  assign step_n    = {q_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{fb}} & step_mask);
  assign count_inc = count_q + WIDTH'(1);

  always_comb begin
    q_d          = q_q;
    ref_d        = ref_q;
    count_d      = count_q;
    period_d     = period_q;
    period_vld_d = period_vld_q;
    wrap_d       = 1'b0;
    seed_err_d   = 1'b0;
    if (load_i) begin
      count_d      = '0;
      period_vld_d = 1'b0;
      if (seed_i != '0) begin
        q_d   = seed_i;
        ref_d = seed_i;
      end else begin
        // A zero seed would lock the register up; fall back to SEED instead.
        q_d        = SEED;
        ref_d      = SEED;
        seed_err_d = 1'b1;
      end
    end else if (en_i) begin
      q_d = step_n;
      if (step_n == ref_q) begin
        wrap_d       = 1'b1;
        period_d     = count_inc;
        period_vld_d = 1'b1;
        count_d      = '0;
      end else begin
        count_d = count_inc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q          <= SEED;
      ref_q        <= SEED;
      count_q      <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      wrap_q       <= 1'b0;
      seed_err_q   <= 1'b0;
    end else begin
      q_q          <= q_d;
      ref_q        <= ref_d;
      count_q      <= count_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      wrap_q       <= wrap_d;
      seed_err_q   <= seed_err_d;
    end
  end

  assign q_o          = q_q;
  assign sout_o       = q_q[WIDTH-1];
  assign count_o      = count_q;
  assign wrap_o       = wrap_q;
  assign period_o     = period_q;
  assign period_vld_o = period_vld_q;
  assign seed_err_o   = seed_err_q;

endmodule

// File: tb/tb_lfsr_param.sv
// Directed bench for lfsr_param: default 6-bit instance (a) and a 4-bit
// x^4+x+1 instance (b) sharing clock and reset.
module tb_lfsr_param;

  logic       clk;
  logic       rst_n;

  logic       en_a, load_a;
  logic [5:0] seed_a, q_a, count_a, period_a;
  logic       sout_a, wrap_a, period_vld_a, seed_err_a;

  logic       en_b, load_b;
  logic [3:0] seed_b, q_b, count_b, period_b;
  logic       sout_b, wrap_b, period_vld_b, seed_err_b;

  int n_checks;
  int n_pass;

  // Hand-computed Galois sequence for TAPS=0010 starting from 0001.
  logic [3:0] seq_b [15] = '{4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110,
                             4'b1100, 4'b1011, 4'b0101, 4'b1010, 4'b0111,
                             4'b1110, 4'b1111, 4'b1101, 4'b1001, 4'b0001};
  logic [5:0] seq_a [5]  = '{6'b111011, 6'b110011, 6'b100011, 6'b000011,
                             6'b000110};

  lfsr_param u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_a), .load_i(load_a), .seed_i(seed_a),
    .q_o(q_a), .sout_o(sout_a), .count_o(count_a), .wrap_o(wrap_a),
    .period_o(period_a), .period_vld_o(period_vld_a), .seed_err_o(seed_err_a)
  );

  lfsr_param #(.WIDTH(4), .TAPS(4'b0010), .SEED(4'b0001)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .load_i(load_b), .seed_i(seed_b),
    .q_o(q_b), .sout_o(sout_b), .count_o(count_b), .wrap_o(wrap_b),
    .period_o(period_b), .period_vld_o(period_vld_b), .seed_err_o(seed_err_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: one active edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1;
    tick();
    tick();
    n_checks++; if (q_a !== 6'b111111) $display("FAIL reset_q_a got %b exp 111111", q_a); else n_pass++;
    n_checks++; if (q_b !== 4'b0001) $display("FAIL reset_q_b got %b exp 0001", q_b); else n_pass++;
    n_checks++; if ({count_b, period_b} !== 8'h00) $display("FAIL reset_cnt_per_b got %h exp 00", {count_b, period_b}); else n_pass++;
    n_checks++; if ({wrap_a, period_vld_a, seed_err_a, wrap_b, period_vld_b, seed_err_b} !== 6'b0)
      $display("FAIL reset_flags got %b exp 000000", {wrap_a, period_vld_a, seed_err_a, wrap_b, period_vld_b, seed_err_b}); else n_pass++;
    en_a = 1'b0; en_b = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_step_defaults();
    en_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (q_a !== seq_a[i]) $display("FAIL step_q_a[%0d] got %b exp %b", i, q_a, seq_a[i]); else n_pass++;
      n_checks++; if (count_a !== 6'(i + 1)) $display("FAIL step_count_a[%0d] got %0d exp %0d", i, count_a, i + 1); else n_pass++;
      n_checks++; if (sout_a !== seq_a[i][5]) $display("FAIL step_sout_a[%0d] got %b exp %b", i, sout_a, seq_a[i][5]); else n_pass++;
    end
    en_a = 1'b0;
  endtask

  task automatic test_wrap_period();
    en_b = 1'b1;
    for (int lap = 0; lap < 2; lap++) begin
      for (int i = 0; i < 15; i++) begin
        tick();
        n_checks++; if (q_b !== seq_b[i]) $display("FAIL wrap_q_b[%0d.%0d] got %b exp %b", lap, i, q_b, seq_b[i]); else n_pass++;
        n_checks++; if (wrap_b !== (i == 14)) $display("FAIL wrap_pulse[%0d.%0d] got %b exp %b", lap, i, wrap_b, (i == 14)); else n_pass++;
        n_checks++; if (count_b !== ((i == 14) ? 4'd0 : 4'(i + 1))) $display("FAIL wrap_count[%0d.%0d] got %0d", lap, i, count_b); else n_pass++;
      end
      n_checks++; if (period_b !== 4'd15) $display("FAIL wrap_period[%0d] got %0d exp 15", lap, period_b); else n_pass++;
      n_checks++; if (period_vld_b !== 1'b1) $display("FAIL wrap_vld[%0d] got %b exp 1", lap, period_vld_b); else n_pass++;
    end
    en_b = 1'b0;
  endtask

  task automatic test_hold();
    en_b = 1'b1;
    tick(); tick(); tick();
    en_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (q_b !== 4'b1000) $display("FAIL hold_q[%0d] got %b exp 1000", i, q_b); else n_pass++;
      n_checks++; if (count_b !== 4'd3) $display("FAIL hold_count[%0d] got %0d exp 3", i, count_b); else n_pass++;
      n_checks++; if ({period_b, wrap_b} !== {4'd15, 1'b0}) $display("FAIL hold_per_wrap[%0d] got %h exp 1e", i, {period_b, wrap_b}); else n_pass++;
    end
  endtask

  task automatic test_seed_load();
    load_b = 1'b1; seed_b = 4'b1010; en_b = 1'b1;
    tick();
    load_b = 1'b0;
    n_checks++; if (q_b !== 4'b1010) $display("FAIL load_q got %b exp 1010", q_b); else n_pass++;
    n_checks++; if ({count_b, period_vld_b} !== 5'b0) $display("FAIL load_cnt_vld got %h exp 0", {count_b, period_vld_b}); else n_pass++;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++; if (wrap_b !== (i == 14)) $display("FAIL load_wrap[%0d] got %b exp %b", i, wrap_b, (i == 14)); else n_pass++;
      if (i < 14) begin
        n_checks++; if (period_vld_b !== 1'b0) $display("FAIL load_vld[%0d] got %b exp 0", i, period_vld_b); else n_pass++;
      end
    end
    n_checks++; if (q_b !== 4'b1010) $display("FAIL load_wrap_q got %b exp 1010", q_b); else n_pass++;
    n_checks++; if ({period_b, period_vld_b} !== {4'd15, 1'b1}) $display("FAIL load_period got %h exp 1f", {period_b, period_vld_b}); else n_pass++;
    en_b = 1'b0;
  endtask

  task automatic test_zero_seed();
    load_a = 1'b1; seed_a = 6'b0; load_b = 1'b1; seed_b = 4'b0;
    tick();
    load_a = 1'b0; load_b = 1'b0;
    n_checks++; if ({q_a, seed_err_a} !== {6'b111111, 1'b1}) $display("FAIL zero_a got %b exp 1111111", {q_a, seed_err_a}); else n_pass++;
    n_checks++; if ({q_b, seed_err_b} !== {4'b0001, 1'b1}) $display("FAIL zero_b got %b exp 00011", {q_b, seed_err_b}); else n_pass++;
    n_checks++; if ({count_b, period_vld_b} !== 5'b0) $display("FAIL zero_cnt_vld got %h exp 0", {count_b, period_vld_b}); else n_pass++;
    tick();
    n_checks++; if ({seed_err_a, seed_err_b} !== 2'b00) $display("FAIL zero_err_width got %b exp 00", {seed_err_a, seed_err_b}); else n_pass++;
    en_b = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++; if (q_b !== seq_b[i] || q_b === 4'b0) $display("FAIL zero_seq[%0d] got %b exp %b", i, q_b, seq_b[i]); else n_pass++;
    end
    n_checks++; if ({wrap_b, period_vld_b, period_b} !== {2'b11, 4'd15}) $display("FAIL zero_wrap got %h exp 3f", {wrap_b, period_vld_b, period_b}); else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) tick();
    en_b = 1'b0;
    n_checks++; if ({q_b, count_b} !== {4'b1011, 4'd7}) $display("FAIL areset_pre got %h exp b7", {q_b, count_b}); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({q_b, count_b, period_b, period_vld_b} !== {4'b0001, 8'h00, 1'b0}) $display("FAIL areset_b got %h exp 200", {q_b, count_b, period_b, period_vld_b}); else n_pass++;
    n_checks++; if (q_a !== 6'b111111) $display("FAIL areset_a got %b exp 111111", q_a); else n_pass++;
    tick();
    rst_n = 1'b1; en_b = 1'b1;
    tick();
    en_b = 1'b0;
    n_checks++; if ({q_b, count_b} !== {4'b0010, 4'd1}) $display("FAIL areset_release got %h exp 21", {q_b, count_b}); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    en_a = 1'b0; load_a = 1'b0; seed_a = '0;
    en_b = 1'b0; load_b = 1'b0; seed_b = '0;
    #2;
    test_reset();
    test_step_defaults();
    test_wrap_period();
    test_hold();
    test_seed_load();
    test_zero_seed();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_param.md
# lfsr_param

Parametrised Galois LFSR with runtime seed loading, step enable and on-line period measurement. It generalises the team's fixed 6-bit all-ones-preset LFSR to any width and tap mask. It adds a measured-period output so benches and BIST logic can confirm a polynomial's cycle length in hardware. It sits beside other test-pattern sources as a pseudo-random stimulus/scrambler generator.

## Interface
- WIDTH, 6, state width in bits; legal range 3..32.
- TAPS, 6'b000100, WIDTH-bit Galois tap mask; bit k (1..WIDTH-1) set means the feedback bit is XORed into stage k; bit 0 ignored.
- SEED, {WIDTH{1'b1}}, reset and fallback state; must be non-zero (elaboration-time error if zero).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  advance state by one step this cycle.
- load  in  1  synchronous seed load; priority over en.
- seed  in  WIDTH  value loaded when load=1.
- q  out  WIDTH  current LFSR state.
- sout  out  1  serial output, equals q[WIDTH-1].
- count  out  WIDTH  steps taken since last load or last wrap.
- wrap  out  1  one-cycle pulse: the state just returned to the reference (loaded) value.
- period  out  WIDTH  measured sequence length, captured at wrap.
- period_vld  out  1  period holds a valid measurement since the last load/reset.
- seed_err  out  1  one-cycle pulse: a zero seed was presented on load and rejected.

## Operation
- Next-state (Galois): fb = q[WIDTH-1]; n[0] = fb; n[k] = q[k-1] ^ (TAPS[k] & fb) for k = 1..WIDTH-1.
- Internal register ref (WIDTH bits) holds the state the sequence started from; not a port.
- Reset (rst=0, asynchronous, independent of clk): q=SEED, ref=SEED, count=0, period=0, period_vld=0, wrap=0, seed_err=0.
- Cycle priority, highest first:
  - load=1, seed!=0: q<=seed, ref<=seed, count<=0, period_vld<=0, wrap<=0, seed_err<=0.
  - load=1, seed==0: q<=SEED, ref<=SEED, count<=0, period_vld<=0, wrap<=0, seed_err<=1. All-zero lock-up state is therefore unreachable.
  - en=1: q<=n. If n==ref: wrap<=1, period<=count+1, period_vld<=1, count<=0. Otherwise wrap<=0, count<=count+1.
  - else: all state held; wrap<=0, seed_err<=0.
- period is held between wraps, so each wrap overwrites it with the latest measurement. period_vld stays 1 until the next load or reset.
- Width rule: any non-zero-start period is at most 2^WIDTH-1, so count+1 never overflows WIDTH bits; no saturation logic.
- en held low never loses state; en may toggle every cycle.
- load and en both high: load wins; no step occurs that cycle.

## Timing
- All outputs are registered; each updates on the rising clk edge following the controlling input. Latency is 1 cycle from en/load to q, count, wrap, period and seed_err.
- sout is combinational from q (same cycle as q).
- wrap and seed_err are exactly one cycle wide. A second wrap can occur no earlier than period cycles later.
- Reset asserted mid-sequence forces the reset values immediately. Release is synchronous to clk; the first step happens on the first edge with rst=1 and en=1.

## Test plan
- Reset and step, defaults: rst low then high; en=1 -> q after reset 6'b111111. Successive q: 111011, 110011, 100011, 000011, 000110. count 1,2,3,4,5; sout follows q[5].
- Wrap/period, WIDTH=4 TAPS=4'b0010 SEED=4'b0001: en=1 continuously -> wrap pulses after the 15th step with q=0001. period=15, period_vld=1, count=0. Next wrap 15 cycles later.
- Seed load: WIDTH=4 mid-run load=1 seed=4'b1010 -> next q=1010, count=0, period_vld=0. wrap occurs 15 steps later with q=1010.
- Zero seed: load=1 seed=0 -> q=SEED, seed_err high for exactly 1 cycle. Sequence continues from SEED, never reaches 0.
- Hold and priority: en=0 for 5 cycles -> q, count, period unchanged, wrap=0. load=1 with en=1 -> load value appears, no step.
- Async reset mid-run: drop rst between clock edges while count=7 -> q=SEED, count=0, period_vld=0 immediately, before the next edge.
